// File: rtl/issue_queue_age.sv
// Unified issue queue: dispatch into free entries, tag-CAM wakeup with latency countdown,
// oldest-first select per issue port, and flush of uops younger than a mispredicted branch.

module iq_src_wake #(
  parameter int ISS_W = 2,
  parameter int TAG_W = 6,
  parameter int LAT_W = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alloc,
  input  logic [TAG_W-1:0]            in_tag,
  input  logic                        in_use,
  input  logic                        in_rdy,
  input  logic [ISS_W-1:0]            bc_vld,
  input  logic [ISS_W-1:0][TAG_W-1:0] bc_tag,
  input  logic [ISS_W-1:0][LAT_W-1:0] bc_lat,
  output logic [TAG_W-1:0]            tag,
  output logic                        rdy
);
  logic             cnt_on;
  logic [LAT_W-1:0] cnt;
  logic [TAG_W-1:0] cmp_tag;
  logic             hit;
  logic [LAT_W-1:0] hit_lat;

  // an incoming uop compares its own tag so it can catch a same-cycle broadcast
  assign cmp_tag = alloc ? in_tag : tag;

  always_comb begin
    hit     = 1'b0;
    hit_lat = '0;
    for (int p = 0; p < ISS_W; p++)
      if (bc_vld[p] && bc_tag[p] == cmp_tag && (!hit || bc_lat[p] < hit_lat)) begin
        hit     = 1'b1;
        hit_lat = bc_lat[p];
      end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag    <= '0;
      rdy    <= 1'b0;
      cnt_on <= 1'b0;
      cnt    <= '0;
    end else begin
      if (alloc) tag <= in_tag;
      if (alloc && (!in_use || in_rdy)) begin
        rdy    <= 1'b1;
        cnt_on <= 1'b0;
      end else if ((alloc || (!rdy && !cnt_on)) && hit) begin
        rdy    <= (hit_lat <= LAT_W'(1));
        cnt_on <= (hit_lat >  LAT_W'(1));
        cnt    <= hit_lat - LAT_W'(1);
      end else if (alloc) begin
        rdy    <= 1'b0;
        cnt_on <= 1'b0;
      end else if (cnt_on && cnt <= LAT_W'(1)) begin
        rdy    <= 1'b1;
        cnt_on <= 1'b0;
      end else if (cnt_on) begin
        cnt <= cnt - LAT_W'(1);
      end
    end
  end
endmodule

module issue_queue_age #(
  parameter  int ENT_NUM = 16,
  parameter  int DISP_W  = 2,
  parameter  int ISS_W   = 2,
  parameter  int TAG_W   = 6,
  parameter  int ROB_W   = 6,
  parameter  int LAT_W   = 3,
  parameter  int PAY_W   = 32,
  localparam int PORT_W  = (ISS_W > 1) ? $clog2(ISS_W) : 1,
  localparam int OCC_W   = $clog2(ENT_NUM) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DISP_W-1:0]             disp_valid,
  output logic                          disp_ready,
  input  logic [DISP_W-1:0][TAG_W-1:0]  disp_src1,
  input  logic [DISP_W-1:0][TAG_W-1:0]  disp_src2,
  input  logic [DISP_W-1:0]             disp_use1,
  input  logic [DISP_W-1:0]             disp_use2,
  input  logic [DISP_W-1:0]             disp_rdy1,
  input  logic [DISP_W-1:0]             disp_rdy2,
  input  logic [DISP_W-1:0][TAG_W-1:0]  disp_dst,
  input  logic [DISP_W-1:0][LAT_W-1:0]  disp_lat,
  input  logic [DISP_W-1:0][PORT_W-1:0] disp_port,
  input  logic [DISP_W-1:0][ROB_W-1:0]  disp_rob,
  input  logic [DISP_W-1:0]             disp_sb,
  input  logic [DISP_W-1:0][PAY_W-1:0]  disp_pay,
  input  logic                          flush,
  input  logic [ROB_W-1:0]              flush_rob,
  input  logic                          flush_sb,
  output logic [ISS_W-1:0]              iss_valid,
  output logic [ISS_W-1:0][TAG_W-1:0]   iss_src1,
  output logic [ISS_W-1:0][TAG_W-1:0]   iss_src2,
  output logic [ISS_W-1:0][TAG_W-1:0]   iss_dst,
  output logic [ISS_W-1:0][ROB_W-1:0]   iss_rob,
  output logic [ISS_W-1:0][PAY_W-1:0]   iss_pay,
  output logic [OCC_W-1:0]              occupancy
);
  localparam int IDX_W  = $clog2(ENT_NUM);
  localparam int SLOT_W = (DISP_W > 1) ? $clog2(DISP_W) : 1;

  typedef struct packed {
    logic [TAG_W-1:0]  dst;
    logic [LAT_W-1:0]  lat;
    logic [PORT_W-1:0] port;
    logic              sb;
    logic [ROB_W-1:0]  rob;
    logic [PAY_W-1:0]  pay;
  } ent_t;

  logic [ENT_NUM-1:0]             vld, rdy1, rdy2, req, we, kill, freed;
  logic [ENT_NUM-1:0][SLOT_W-1:0] we_slot;
  logic [ENT_NUM-1:0][TAG_W-1:0]  src1, src2;
  ent_t                           ent [ENT_NUM];
  logic [ISS_W-1:0]               gnt_found, gnt_ok;
  logic [ISS_W-1:0][IDX_W-1:0]    gnt_idx;
  logic [ISS_W-1:0][TAG_W-1:0]    bc_tag;
  logic [ISS_W-1:0][LAT_W-1:0]    bc_lat;

  function automatic logic older(input logic sa, input logic [ROB_W-1:0] ra,
                                 input logic sc, input logic [ROB_W-1:0] rc);
    return (sa == sc) ? (ra < rc) : (ra > rc);
  endfunction

  always_comb begin
    occupancy = '0;
    for (int e = 0; e < ENT_NUM; e++) occupancy += OCC_W'(vld[e]);
  end

  assign disp_ready = (int'(occupancy) <= ENT_NUM - DISP_W) && !flush;

  // slot d takes the d-th lowest free entry; an idle slot still consumes its position
  always_comb begin
    int nf;
    nf      = 0;
    we      = '0;
    we_slot = '0;
    for (int e = 0; e < ENT_NUM; e++)
      if (!vld[e] && nf < DISP_W) begin
        if (disp_ready && disp_valid[SLOT_W'(nf)]) begin
          we[e]      = 1'b1;
          we_slot[e] = SLOT_W'(nf);
        end
        nf++;
      end
  end

  assign req = vld & rdy1 & rdy2;

  always_comb begin
    for (int e = 0; e < ENT_NUM; e++)
      kill[e] = flush && vld[e] && older(flush_sb, flush_rob, ent[e].sb, ent[e].rob);
  end

  always_comb begin
    gnt_found = '0;
    gnt_idx   = '0;
    for (int p = 0; p < ISS_W; p++)
      for (int e = 0; e < ENT_NUM; e++)
        if (req[e] && ent[e].port == PORT_W'(p) &&
            (!gnt_found[p] || older(ent[e].sb, ent[e].rob,
                                    ent[gnt_idx[p]].sb, ent[gnt_idx[p]].rob))) begin
          gnt_found[p] = 1'b1;
          gnt_idx[p]   = IDX_W'(e);
        end
  end

  // squashed grants neither issue nor broadcast a wakeup
  always_comb begin
    freed = '0;
    for (int p = 0; p < ISS_W; p++) begin
      gnt_ok[p] = gnt_found[p] && !kill[gnt_idx[p]];
      bc_tag[p] = ent[gnt_idx[p]].dst;
      bc_lat[p] = ent[gnt_idx[p]].lat;
      if (gnt_ok[p]) freed[gnt_idx[p]] = 1'b1;
    end
  end

  for (genvar e = 0; e < ENT_NUM; e++) begin : g_ent
    iq_src_wake #(.ISS_W(ISS_W), .TAG_W(TAG_W), .LAT_W(LAT_W)) u_src1 (
      .clk, .reset, .alloc(we[e]),
      .in_tag(disp_src1[we_slot[e]]), .in_use(disp_use1[we_slot[e]]), .in_rdy(disp_rdy1[we_slot[e]]),
      .bc_vld(gnt_ok), .bc_tag, .bc_lat, .tag(src1[e]), .rdy(rdy1[e]));
    iq_src_wake #(.ISS_W(ISS_W), .TAG_W(TAG_W), .LAT_W(LAT_W)) u_src2 (
      .clk, .reset, .alloc(we[e]),
      .in_tag(disp_src2[we_slot[e]]), .in_use(disp_use2[we_slot[e]]), .in_rdy(disp_rdy2[we_slot[e]]),
      .bc_vld(gnt_ok), .bc_tag, .bc_lat, .tag(src2[e]), .rdy(rdy2[e]));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      for (int e = 0; e < ENT_NUM; e++) ent[e] <= '0;
    end else begin
      for (int e = 0; e < ENT_NUM; e++)
        if (we[e]) begin
          vld[e] <= 1'b1;
          ent[e] <= '{dst:  disp_dst[we_slot[e]],  lat: disp_lat[we_slot[e]],
                      port: disp_port[we_slot[e]], sb:  disp_sb[we_slot[e]],
                      rob:  disp_rob[we_slot[e]],  pay: disp_pay[we_slot[e]]};
        end else if (freed[e] || kill[e]) begin
          vld[e] <= 1'b0;
        end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iss_valid <= '0;
      iss_src1  <= '0;
      iss_src2  <= '0;
      iss_dst   <= '0;
      iss_rob   <= '0;
      iss_pay   <= '0;
    end else begin
      for (int p = 0; p < ISS_W; p++) begin
        iss_valid[p] <= gnt_ok[p];
        if (gnt_ok[p]) begin
          iss_src1[p] <= src1[gnt_idx[p]];
          iss_src2[p] <= src2[gnt_idx[p]];
          iss_dst[p]  <= ent[gnt_idx[p]].dst;
          iss_rob[p]  <= ent[gnt_idx[p]].rob;
          iss_pay[p]  <= ent[gnt_idx[p]].pay;
        end
      end
    end
  end
endmodule

// File: tb/tb_issue_queue_age.sv
// Directed bench for issue_queue_age: dispatch, wakeup latency, age select, full, flush, reset.

module tb_issue_queue_age;
  localparam int DISP_W = 2, ISS_W = 2, TAG_W = 6, ROB_W = 6, LAT_W = 3, PAY_W = 32, PORT_W = 1;

  logic clk = 1'b0, reset = 1'b0;
  logic [DISP_W-1:0]             disp_valid, disp_use1, disp_use2, disp_rdy1, disp_rdy2, disp_sb;
  logic                          disp_ready;
  logic [DISP_W-1:0][TAG_W-1:0]  disp_src1, disp_src2, disp_dst;
  logic [DISP_W-1:0][LAT_W-1:0]  disp_lat;
  logic [DISP_W-1:0][PORT_W-1:0] disp_port;
  logic [DISP_W-1:0][ROB_W-1:0]  disp_rob;
  logic [DISP_W-1:0][PAY_W-1:0]  disp_pay;
  logic                          flush, flush_sb;
  logic [ROB_W-1:0]              flush_rob;
  logic [ISS_W-1:0]              iss_valid;
  logic [ISS_W-1:0][TAG_W-1:0]   iss_src1, iss_src2, iss_dst;
  logic [ISS_W-1:0][ROB_W-1:0]   iss_rob;
  logic [ISS_W-1:0][PAY_W-1:0]   iss_pay;
  logic [4:0]                    occupancy;
  int n_chk = 0, n_fail = 0;

  issue_queue_age dut (
    .clk(clk), .reset(reset), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_src1(disp_src1), .disp_src2(disp_src2), .disp_use1(disp_use1), .disp_use2(disp_use2),
    .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2), .disp_dst(disp_dst), .disp_lat(disp_lat),
    .disp_port(disp_port), .disp_rob(disp_rob), .disp_sb(disp_sb), .disp_pay(disp_pay),
    .flush(flush), .flush_rob(flush_rob), .flush_sb(flush_sb),
    .iss_valid(iss_valid), .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_dst(iss_dst),
    .iss_rob(iss_rob), .iss_pay(iss_pay), .occupancy(occupancy));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = '0; disp_use1 = '0; disp_use2 = '0; disp_rdy1 = '0; disp_rdy2 = '0;
    disp_sb = '0; disp_src1 = '0; disp_src2 = '0; disp_dst = '0; disp_lat = '0;
    disp_port = '0; disp_rob = '0; disp_pay = '0;
  endtask

  // src2 unused on every uop; src1 used, ready at rename when r1
  task automatic slot(input int d, input logic [5:0] s1, input logic r1, input logic [5:0] dst,
                      input logic [2:0] lat, input logic port, input logic [5:0] rob, input logic sb);
    disp_valid[d] = 1'b1; disp_src1[d] = s1; disp_use1[d] = 1'b1; disp_rdy1[d] = r1;
    disp_src2[d] = 6'd63; disp_use2[d] = 1'b0; disp_rdy2[d] = 1'b0;
    disp_dst[d] = dst; disp_lat[d] = lat; disp_port[d] = port; disp_rob[d] = rob; disp_sb[d] = sb;
    disp_pay[d] = 32'hA000_0000 | {26'h0, rob};
  endtask

  initial begin
    idle(); flush = 1'b0; flush_sb = 1'b0; flush_rob = '0;
    tick(); tick();
    chk("rst_iss_valid", 64'(iss_valid), 0);
    chk("rst_occ", 64'(occupancy), 0);
    chk("rst_disp_ready", 64'(disp_ready), 1);
    chk("rst_iss_dst", 64'(iss_dst), 0);
    reset = 1'b1; tick();

    // two independent ready uops, one per port
    slot(0, 0, 1, 10, 1, 0, 0, 0); slot(1, 0, 1, 11, 1, 1, 1, 0);
    tick(); idle();
    chk("t1_occ2", 64'(occupancy), 2);
    tick();
    chk("t1_iss_valid", 64'(iss_valid), 2'b11);
    chk("t1_dst0", 64'(iss_dst[0]), 10);
    chk("t1_dst1", 64'(iss_dst[1]), 11);
    chk("t1_rob1", 64'(iss_rob[1]), 1);
    chk("t1_pay0", 64'(iss_pay[0]), 32'hA000_0000);
    chk("t1_occ0", 64'(occupancy), 0);
    tick();
    chk("t1_idle", 64'(iss_valid), 0);

    // lat=1 producer -> back-to-back consumer
    slot(0, 0, 1, 7, 1, 0, 2, 0); slot(1, 7, 0, 8, 1, 1, 3, 0);
    tick(); idle();
    tick();
    chk("t2_prod", 64'(iss_valid), 2'b01);
    chk("t2_prod_dst", 64'(iss_dst[0]), 7);
    tick();
    chk("t2_b2b", 64'(iss_valid), 2'b10);
    chk("t2_cons_src1", 64'(iss_src1[1]), 7);
    tick();
    chk("t2_idle", 64'(iss_valid), 0);

    // lat=3 producer: consumer granted 3 cycles after producer grant
    slot(0, 0, 1, 9, 3, 0, 4, 0); slot(1, 9, 0, 12, 1, 1, 5, 0);
    tick(); idle();
    tick();
    chk("t2l3_prod", 64'(iss_valid), 2'b01);
    tick();
    chk("t2l3_wait1", 64'(iss_valid), 0);
    tick();
    chk("t2l3_wait2", 64'(iss_valid), 0);
    tick();
    chk("t2l3_cons", 64'(iss_valid), 2'b10);
    chk("t2l3_cons_dst", 64'(iss_dst[1]), 12);

    // age order, same sorting bit: rob 5,2 then 9
    slot(0, 0, 1, 20, 1, 0, 5, 0); slot(1, 0, 1, 21, 1, 0, 2, 0);
    tick(); idle(); slot(0, 0, 1, 22, 1, 0, 9, 0);
    tick(); idle();
    chk("t3_v1", 64'(iss_valid), 2'b01);
    chk("t3_rob2", 64'(iss_rob[0]), 2);
    tick();
    chk("t3_rob5", 64'(iss_rob[0]), 5);
    tick();
    chk("t3_rob9", 64'(iss_rob[0]), 9);
    tick();
    chk("t3_idle", 64'(iss_valid), 0);

    // sorting-bit wrap: rob 62 sb0 older than rob 1 sb1
    slot(0, 0, 1, 23, 1, 0, 1, 1); slot(1, 0, 1, 24, 1, 0, 62, 0);
    tick(); idle();
    tick();
    chk("t3_sb_first", 64'(iss_rob[0]), 62);
    tick();
    chk("t3_sb_second", 64'(iss_rob[0]), 1);
    chk("t3_sb_valid", 64'(iss_valid), 2'b01);

    // flush at rob 4: 6,8 dropped (8 was ready -> grant squashed), 3 and 4 survive
    slot(0, 60, 0, 30, 1, 0, 3, 0); slot(1, 60, 0, 31, 1, 1, 4, 0);
    tick();
    slot(0, 60, 0, 32, 1, 0, 6, 0); slot(1, 0, 1, 33, 1, 1, 8, 0);
    tick(); idle();
    chk("t5_occ4", 64'(occupancy), 4);
    flush = 1'b1; flush_rob = 6'd4; flush_sb = 1'b0;
    slot(0, 60, 0, 34, 1, 0, 7, 0);
    #1;
    chk("t5_ready_flush", 64'(disp_ready), 0);
    tick(); flush = 1'b0; idle();
    chk("t5_occ2", 64'(occupancy), 2);
    chk("t5_squash", 64'(iss_valid), 0);
    slot(0, 0, 1, 60, 1, 0, 5, 0);
    tick(); idle();
    chk("t5_occ3", 64'(occupancy), 3);
    tick();
    chk("t5_wake_prod", 64'(iss_valid), 2'b01);
    chk("t5_wake_rob", 64'(iss_rob[0]), 5);
    tick();
    chk("t5_kept_valid", 64'(iss_valid), 2'b11);
    chk("t5_kept_rob3", 64'(iss_rob[0]), 3);
    chk("t5_kept_rob4", 64'(iss_rob[1]), 4);
    chk("t5_occ0", 64'(occupancy), 0);

    // fill to 14 waiting, one ready uop -> 15 (full), it issues -> 14 and ready again
    for (int i = 0; i < 7; i++) begin
      slot(0, 50, 0, 0, 1, 0, 6'(10 + 2*i), 0); slot(1, 50, 0, 0, 1, 0, 6'(11 + 2*i), 0);
      tick();
    end
    idle();
    chk("t4_occ14", 64'(occupancy), 14);
    chk("t4_ready14", 64'(disp_ready), 1);
    slot(0, 0, 1, 40, 1, 1, 30, 0);
    tick(); idle();
    chk("t4_occ15", 64'(occupancy), 15);
    chk("t4_full", 64'(disp_ready), 0);
    slot(0, 50, 0, 0, 1, 0, 31, 0); slot(1, 50, 0, 0, 1, 0, 32, 0);
    tick();
    chk("t4_iss", 64'(iss_valid), 2'b10);
    chk("t4_iss_rob", 64'(iss_rob[1]), 30);
    chk("t4_no_accept", 64'(occupancy), 14);
    chk("t4_ready_again", 64'(disp_ready), 1);
    tick(); idle();
    chk("t4_occ16", 64'(occupancy), 16);
    chk("t4_full16", 64'(disp_ready), 0);

    reset = 1'b0; #1;
    chk("rst_mid_occ", 64'(occupancy), 0);
    tick(); reset = 1'b1; tick();

    // reset while a consumer counts down
    slot(0, 0, 1, 33, 3, 0, 0, 0); slot(1, 33, 0, 34, 1, 1, 1, 0);
    tick(); idle();
    tick();
    chk("t6_prod", 64'(iss_valid), 2'b01);
    reset = 1'b0; #1;
    chk("t6_rst_valid", 64'(iss_valid), 0);
    chk("t6_rst_occ", 64'(occupancy), 0);
    tick(); reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_issue", 64'(iss_valid), 0);
    end
    chk("t6_occ_end", 64'(occupancy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
